// File: rtl/gpu_pkg.sv
// gpu_pkg: shared colour/layer types and pixel timing defaults for the sprite pipeline
package gpu_pkg;
  localparam int RGB_W = 12;
  localparam int PIXEL_CLKS_DEF = 4;
  typedef logic [RGB_W-1:0] colour_t;
  typedef logic [1:0] layer_t;
endpackage

// File: rtl/pixel_arbiter_if.sv
// pixel_arbiter_if: blob read-request bus plus sprite-RAM write port
interface pixel_arbiter_if
  import gpu_pkg::*;
#(
  parameter int ADD_WIDTH = 16,
  parameter int NR_OF_BLOBS = 4
);
  layer_t [NR_OF_BLOBS-1:0] layer;
  logic [NR_OF_BLOBS-1:0][ADD_WIDTH-1:0] address;
  logic [NR_OF_BLOBS-1:0] request;
  logic [ADD_WIDTH-1:0] wr_add;
  colour_t wr_data;
  logic wr_req;
  modport master (output layer, address, request, wr_add, wr_data, wr_req);
  modport slave (input layer, address, request, wr_add, wr_data, wr_req);
endinterface

// File: rtl/pixel_arbiter_sprite_ram.sv
// sprite_ram: 1W/1R synchronous read-first RAM, inferable as block RAM
module sprite_ram
  import gpu_pkg::*;
#(
  parameter int ADD_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADD_WIDTH-1:0] i_wa,
  input  colour_t              i_wd,
  input  logic [ADD_WIDTH-1:0] i_ra,
  output colour_t              o_rd
);
  colour_t r_mem [2**ADD_WIDTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wa] <= i_wd;
    o_rd <= r_mem[i_ra];
  end
endmodule

// File: rtl/pixel_arbiter.sv
// pixel_arbiter: picks the top-layer requesting blob, reads its sprite pixel and holds it for one pixel period
module pixel_arbiter
  import gpu_pkg::*;
#(
  parameter int ADD_WIDTH = 16,
  parameter int NR_OF_BLOBS = 4,
  parameter int NR_OF_RAMS = 1,
  parameter int PIXEL_CLKS = PIXEL_CLKS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  colour_t               background,
  pixel_arbiter_if.slave        bus,
  output colour_t               pixel_send
);
  localparam int HW = $clog2(PIXEL_CLKS + 1);
  if (NR_OF_RAMS != 1) begin : g_bad_rams
    $error("pixel_arbiter supports exactly one sprite RAM bank");
  end
  logic [ADD_WIDTH-1:0] w_win_addr, r_addr;
  logic w_any, r_v1, r_v2;
  layer_t w_best;
  logic [HW-1:0] r_hold;
  colour_t w_rdata;
  // strict compare keeps the lowest index on equal layers
  always_comb begin
    w_any = 1'b0;
    w_best = '0;
    w_win_addr = '0;
    for (int i = 0; i < NR_OF_BLOBS; i++) begin
      if (bus.request[i] && (!w_any || bus.layer[i] > w_best)) begin
        w_any = 1'b1;
        w_best = bus.layer[i];
        w_win_addr = bus.address[i];
      end
    end
  end
  always_ff @(posedge clk) r_addr <= w_win_addr;
  sprite_ram #(.ADD_WIDTH(ADD_WIDTH)) u_ram (
    .clk  (clk),
    .i_we (bus.wr_req),
    .i_wa (bus.wr_add),
    .i_wd (bus.wr_data),
    .i_ra (r_addr),
    .o_rd (w_rdata)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_hold <= '0;
      pixel_send <= '0;
    end else begin
      r_v1 <= w_any;
      r_v2 <= r_v1;
      if (r_v2) begin
        pixel_send <= w_rdata;
        r_hold <= HW'(PIXEL_CLKS - 1);
      end else if (|r_hold) r_hold <= r_hold - HW'(1);
      else pixel_send <= background;
    end
  end
endmodule

// File: tb/tb_pixel_arbiter.sv
// tb_pixel_arbiter: vector table, corner sequences and random traffic against a timestamp-based model
module tb_pixel_arbiter;
  import gpu_pkg::*;
  localparam int PC = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0][1:0] lay = '0;
  logic [3:0][15:0] adr = '0;
  logic wr = 1'b0;
  logic [15:0] wa = '0;
  logic [11:0] wd = '0;
  logic [11:0] bg = 12'hABC;
  colour_t pixel_send;
  int n_tests = 0, n_fail = 0, cyc = 0;
  always #5 clk = ~clk;
  pixel_arbiter_if #(.ADD_WIDTH(16), .NR_OF_BLOBS(4)) bus ();
  assign bus.request = req;
  assign bus.layer = lay;
  assign bus.address = adr;
  assign bus.wr_req = wr;
  assign bus.wr_add = wa;
  assign bus.wr_data = wd;
  pixel_arbiter #(.ADD_WIDTH(16), .NR_OF_BLOBS(4), .NR_OF_RAMS(1), .PIXEL_CLKS(PC)) dut (
    .clk        (clk),
    .reset      (rst),
    .background (bg),
    .bus        (bus),
    .pixel_send (pixel_send)
  );
  typedef struct { int t; int a; logic [11:0] v; } ev_t;
  ev_t rd_q[$], sh_q[$];
  logic [11:0] mem_m [int];
  logic [11:0] m_exp = '0;
  int last_show = -1000;
  task automatic check(string nm, logic [11:0] act, logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // spec view: highest layer among requesters, then lowest index holding that layer
  function automatic int winner();
    int maxl = -1;
    for (int i = 0; i < 4; i++) if (req[i] && int'(lay[i]) > maxl) maxl = int'(lay[i]);
    for (int i = 0; i < 4; i++) if (req[i] && int'(lay[i]) == maxl) return i;
    return -1;
  endfunction
  task automatic model_step(int t);
    bit shown = 0;
    if (rst) begin
      rd_q.delete();
      sh_q.delete();
      m_exp = '0;
      last_show = -1000;
    end else begin
      while (rd_q.size() > 0 && rd_q[0].t == t) begin
        sh_q.push_back('{t + 1, rd_q[0].a, mem_m[rd_q[0].a]});
        void'(rd_q.pop_front());
      end
      while (sh_q.size() > 0 && sh_q[0].t == t) begin
        m_exp = sh_q[0].v;
        last_show = t;
        shown = 1;
        void'(sh_q.pop_front());
      end
      if (!shown && t - last_show >= PC) m_exp = bg;
      if (req != 0) rd_q.push_back('{t + 1, int'(adr[winner()]), 12'h0});
    end
    if (wr) mem_m[int'(wa)] = wd;
  endtask
  task automatic tick();
    model_step(cyc);
    @(posedge clk);
    @(negedge clk);
    check("model", pixel_send, m_exp);
    cyc++;
  endtask
  task automatic write(int a, logic [11:0] d);
    wr = 1'b1; wa = 16'(a); wd = d;
    tick();
    wr = 1'b0;
  endtask
  task automatic one_req(int a, logic [11:0] exp, string nm);
    req = 4'b0001; lay = '0; adr = '0; adr[0] = 16'(a);
    tick();
    req = '0;
    tick();
    tick();
    check(nm, pixel_send, exp);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  function automatic logic [15:0] blob_addr(int x, int y);
    return 16'(50 + (y - 5) * (6 - 3 + 1) + (x - 3));
  endfunction
  typedef struct packed {
    logic [3:0] req;
    logic [3:0][1:0] lay;
    logic [3:0][15:0] adr;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[6];
  initial begin
    int xs[5], ys[5], hits;
    logic [11:0] rexp[5];
    bit stale;
    vecs[0] = '{4'b1111, {2'd0, 2'd1, 2'd2, 2'd3}, {16'd150, 16'd100, 16'd1, 16'd50}, 12'hF00};
    vecs[1] = '{4'b1110, {2'd0, 2'd1, 2'd2, 2'd3}, {16'd150, 16'd100, 16'd1, 16'd50}, 12'h0F0};
    vecs[2] = '{4'b1100, {2'd2, 2'd2, 2'd2, 2'd2}, {16'd150, 16'd100, 16'd1, 16'd50}, 12'h00F};
    vecs[3] = '{4'b1000, {2'd0, 2'd1, 2'd2, 2'd3}, {16'd150, 16'd100, 16'd1, 16'd50}, 12'hFFF};
    vecs[4] = '{4'b1111, {2'd0, 2'd0, 2'd0, 2'd0}, {16'd150, 16'd100, 16'd1, 16'd50}, 12'hF00};
    vecs[5] = '{4'b1111, {2'd3, 2'd3, 2'd1, 2'd1}, {16'd150, 16'd100, 16'd1, 16'd50}, 12'h00F};
    idle(3);
    check("reset_state", pixel_send, 12'h000);
    rst = 1'b0;
    tick();
    check("bg_after_reset", pixel_send, 12'hABC);
    write(50, 12'hF00); write(1, 12'h0F0); write(100, 12'h00F); write(150, 12'hFFF);
    write(55, 12'h555); write(61, 12'h616);
    for (int a = 0; a < 16; a++) if (a != 1) write(a, 12'($urandom));
    for (int v = 0; v < 6; v++) begin
      req = vecs[v].req; lay = vecs[v].lay; adr = vecs[v].adr;
      tick();
      req = '0;
      tick();
      tick();
      check($sformatf("vec%0d", v), pixel_send, vecs[v].exp);
      idle(5);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bg_idle", pixel_send, 12'hABC);
    end
    req = 4'b0001; lay = '0; adr = '0; adr[0] = 16'd50;
    tick();
    req = '0;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pixel_send == 12'hF00) hits++;
    end
    check("hold_len", 12'(hits), 12'(PC));
    check("hold_then_bg", pixel_send, 12'hABC);
    xs = '{3, 4, 6, 2, 7};
    ys = '{5, 6, 7, 5, 7};
    rexp = '{12'hF00, 12'h555, 12'h616, 12'hABC, 12'hABC};
    for (int p = 0; p < 5; p++) begin
      req = {3'b0, xs[p] >= 3 && xs[p] <= 6 && ys[p] >= 5 && ys[p] <= 7};
      lay = '0; lay[0] = 2'd1; adr = '0; adr[0] = blob_addr(xs[p], ys[p]);
      tick();
      req = '0;
      tick();
      tick();
      check($sformatf("rect_%0d_%0d", xs[p], ys[p]), pixel_send, rexp[p]);
      idle(4);
    end
    req = 4'b0001; lay = '0; adr = '0; adr[0] = 16'd50;
    tick();
    req = '0; rst = 1'b1;
    tick();
    check("rst_mid_0", pixel_send, 12'h000);
    tick();
    check("rst_mid_1", pixel_send, 12'h000);
    rst = 1'b0;
    tick();
    check("rst_release_bg", pixel_send, 12'hABC);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pixel_send == 12'hF00) stale = 1;
    end
    check("no_stale", {11'b0, stale}, 12'h000);
    req = 4'b0001; lay = '0; adr = '0; adr[0] = 16'd55;
    tick();
    req = '0; wr = 1'b1; wa = 16'd55; wd = 12'hA55;
    tick();
    wr = 1'b0;
    tick();
    check("rw_same_old", pixel_send, 12'h555);
    idle(5);
    one_req(55, 12'hA55, "rw_next_new");
    idle(5);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      req = $urandom_range(0, 1) ? 4'($urandom) : 4'b0;
      lay = 8'($urandom);
      for (int b = 0; b < 4; b++) adr[b] = 16'($urandom_range(0, 15));
      wr = ($urandom_range(0, 2) == 0);
      wa = 16'($urandom_range(0, 15));
      wd = 12'($urandom);
      if ($urandom_range(0, 9) == 0) bg = 12'($urandom);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
